serial_deser: RTL and testbench
===============================

// Module: serial_deser
// PURPOSE
//   Serial-to-parallel receiver: the far end of a link driven by our universal
//   shift register in shift mode. Collects WIDTH serial bits framed by a start
//   strobe into a word, then presents it on a double-buffered valid/ready output
//   port. Reception of the next frame overlaps with the current word waiting to
//   be taken. Overflow is flagged and sticky.
// PARAMETERS
//   WIDTH      8   bits per frame/word (>=2)
//   MSB_FIRST  0   0: first bit received -> dout[0]; 1: first bit -> dout[WIDTH-1]
// PORTS
//   clk         in   1      single clock, all logic on rising edge
//   reset       in   1      asynchronous, active-low; clears all state
//   sin         in   1      serial data bit
//   sin_valid   in   1      sin is sampled on this edge when 1
//   start       in   1      with sin_valid: this bit is bit 0 of a new frame
//   dout        out  WIDTH  received word (holding register)
//   dout_valid  out  1      dout holds an untaken word
//   dout_ready  in   1      consumer accepts dout when dout_valid & dout_ready
//   busy        out  1      frame in progress (state SHIFT)
//   bit_cnt     out  clog2(WIDTH+1)  bits captured in current frame
//   overrun     out  1      sticky: a completed word was dropped
//   clr_ovr     in   1      synchronous clear of overrun
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, shreg=0, dout=0, dout_valid=0, busy=0,
//     bit_cnt=0, overrun=0. Release is synchronous to clk.
//   Shift: MSB_FIRST=0 -> shreg <= {sin, shreg[WIDTH-1:1]};
//          MSB_FIRST=1 -> shreg <= {shreg[WIDTH-2:0], sin}.
//   FSM: IDLE -> SHIFT on sin_valid&start (bit captured, bit_cnt=1).
//     SHIFT: each sin_valid captures one bit, bit_cnt+1. sin_valid=0: hold.
//     Capture of bit WIDTH (final bit) -> frame complete, go IDLE, bit_cnt=0.
//     start&sin_valid in SHIFT: partial frame discarded silently, restart with
//       this bit as bit 0 (bit_cnt=1), no flag.
//     In IDLE, sin_valid without start is ignored.
//     WIDTH=... start on final bit: start wins (restart), frame not completed.
//   Completion: on the completing edge the full word (incl. final bit) is
//     written to dout if the holding register is free or being taken this
//     cycle (!dout_valid | dout_ready); dout_valid=1 next cycle. Latency:
//     dout_valid rises the cycle after the final sin_valid edge.
//     Holding full and dout_ready=0: new word dropped, dout/dout_valid kept,
//     overrun<=1.
//   Handshake: dout_valid & dout_ready with no completion -> dout_valid<=0,
//     dout unchanged. Simultaneous take+completion -> dout reloaded,
//     dout_valid stays 1, no overrun. dout stable while dout_valid&!dout_ready.
//   overrun: set as above; clr_ovr clears; set and clr same edge -> stays 1.
//   busy = (state==SHIFT). Mid-frame reset: frame lost, all outputs to reset
//     values immediately.
// TESTING
//   1 WIDTH=8,LSB-first: start+bits of 0xA5 LSB-first, 8 consecutive sin_valid,
//     ready=1 -> dout=0xA5, dout_valid one cycle after bit 8, drops next cycle.
//   2 MSB_FIRST=1: shift 0x3C MSB-first with sin_valid gaps of 0-3 cycles ->
//     dout=0x3C; bit_cnt tracks 1..7, busy high throughout.
//   3 ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun=1; ready=1 ->
//     0x11 taken, dout_valid=0; clr_ovr -> overrun=0.
//   4 Word 0x11 waiting; ready asserted on exact completing edge of 0x22 ->
//     dout=0x22, dout_valid continuously 1, overrun=0.
//   5 After 5 bits of a frame assert start with new frame 0x5A -> only 0x5A
//     delivered; reset low at bit 4 of a frame -> all outputs 0 immediately,
//     next complete frame received correctly.

Source files
------------

// File: rtl/serial_deser_if.sv
// Bundles the serial input, parallel valid/ready output and status signals of
// the serial-to-parallel receiver.
interface serial_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_valid;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             clr_ovr;

    modport master (
        output sin, sin_valid, start, dout_ready, clr_ovr,
        input  dout, dout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_valid, start, dout_ready, clr_ovr,
        output dout, dout_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: collects WIDTH start-framed bits into a word and
// presents it through a single holding register with valid/ready and sticky overrun.
module serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    serial_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shreg_next;
    logic             w_restart;
    logic             w_shift;
    logic             w_complete;
    logic             w_hold_free;

    assign w_shreg_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], bus.sin}
                                    : {bus.sin, r_shreg[WIDTH-1:1]};

    // A start strobe always wins, even on what would have been the final bit.
    assign w_restart   = bus.sin_valid & bus.start;
    assign w_shift     = bus.sin_valid & ~bus.start & (r_state == S_SHIFT);
    assign w_complete  = w_shift & (r_bit_cnt == CW'(WIDTH - 1));
    assign w_hold_free = ~r_dout_valid | bus.dout_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_bit_cnt    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_restart) begin
                r_state   <= S_SHIFT;
                r_shreg   <= w_shreg_next;
                r_bit_cnt <= CW'(1);
            end else if (w_shift) begin
                r_shreg <= w_shreg_next;
                if (w_complete) begin
                    r_state   <= S_IDLE;
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end

            // Holding register: reload on completion if free or being taken.
            if (w_complete && w_hold_free) begin
                r_dout       <= w_shreg_next;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            // Setting has priority over a simultaneous clear.
            if (w_complete && !w_hold_free) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state == S_SHIFT);
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: an LSB-first and an MSB-first instance on a
// shared clock/reset, driven through their interfaces.
module tb_serial_deser;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    serial_deser_if #(.WIDTH(8)) ifl ();
    serial_deser_if #(.WIDTH(8)) ifm ();

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifl.slave)
    );

    serial_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit_l(input logic b, input logic st);
        ifl.sin       = b;
        ifl.sin_valid = 1'b1;
        ifl.start     = st;
        tick();
        ifl.sin_valid = 1'b0;
        ifl.start     = 1'b0;
    endtask

    task automatic send_frame_l(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit_l(w[i], i == 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        ifl.sin = 1'b0; ifl.sin_valid = 1'b0; ifl.start = 1'b0;
        ifl.dout_ready = 1'b1; ifl.clr_ovr = 1'b0;
        ifm.sin = 1'b0; ifm.sin_valid = 1'b0; ifm.start = 1'b0;
        ifm.dout_ready = 1'b1; ifm.clr_ovr = 1'b0;

        // Reset state
        #2;
        chk("rst_dout",    32'(ifl.dout), 32'h0);
        chk("rst_valid",   32'(ifl.dout_valid), 32'h0);
        chk("rst_busy",    32'(ifl.busy), 32'h0);
        chk("rst_cnt",     32'(ifl.bit_cnt), 32'h0);
        chk("rst_ovr",     32'(ifl.overrun), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // 1: 0xA5 LSB-first, back-to-back bits, ready=1
        for (int i = 0; i < 8; i++) begin
            send_bit_l(8'hA5 >> i, i == 0);
            if (i == 3) chk("t1_cnt4", 32'(ifl.bit_cnt), 32'd4);
        end
        chk("t1_valid",  32'(ifl.dout_valid), 32'h1);
        chk("t1_dout",   32'(ifl.dout), 32'hA5);
        chk("t1_busy",   32'(ifl.busy), 32'h0);
        chk("t1_cnt0",   32'(ifl.bit_cnt), 32'h0);
        tick();
        chk("t1_drop",   32'(ifl.dout_valid), 32'h0);
        chk("t1_keep",   32'(ifl.dout), 32'hA5);

        // 2: 0x3C MSB-first with 0..3 idle cycles between bits
        for (int i = 0; i < 8; i++) begin
            ifm.sin       = (8'h3C >> (7 - i)) & 8'h1;
            ifm.sin_valid = 1'b1;
            ifm.start     = (i == 0);
            tick();
            ifm.sin_valid = 1'b0;
            ifm.start     = 1'b0;
            if (i < 7) begin
                chk("t2_cnt",  32'(ifm.bit_cnt), 32'(i + 1));
                chk("t2_busy", 32'(ifm.busy), 32'h1);
                for (int g = 0; g < (i % 4); g++) tick();
                chk("t2_hold", 32'(ifm.bit_cnt), 32'(i + 1));
            end
        end
        chk("t2_valid", 32'(ifm.dout_valid), 32'h1);
        chk("t2_dout",  32'(ifm.dout), 32'h3C);
        chk("t2_busy0", 32'(ifm.busy), 32'h0);

        // 3: overrun with ready low, then take and clear
        ifl.dout_ready = 1'b0;
        send_frame_l(8'h11);
        chk("t3_v1",    32'(ifl.dout_valid), 32'h1);
        chk("t3_d1",    32'(ifl.dout), 32'h11);
        chk("t3_novr",  32'(ifl.overrun), 32'h0);
        send_frame_l(8'h22);
        chk("t3_keep",  32'(ifl.dout), 32'h11);
        chk("t3_vkeep", 32'(ifl.dout_valid), 32'h1);
        chk("t3_ovr",   32'(ifl.overrun), 32'h1);
        ifl.dout_ready = 1'b1;
        tick();
        ifl.dout_ready = 1'b0;
        chk("t3_taken", 32'(ifl.dout_valid), 32'h0);
        chk("t3_dout",  32'(ifl.dout), 32'h11);
        chk("t3_ovrst", 32'(ifl.overrun), 32'h1);
        ifl.clr_ovr = 1'b1;
        tick();
        ifl.clr_ovr = 1'b0;
        chk("t3_clr",   32'(ifl.overrun), 32'h0);

        // 4: take on the exact completing edge of the next word
        send_frame_l(8'h11);
        for (int i = 0; i < 7; i++) send_bit_l(8'h22 >> i, i == 0);
        chk("t4_vpre",  32'(ifl.dout_valid), 32'h1);
        chk("t4_dpre",  32'(ifl.dout), 32'h11);
        ifl.dout_ready = 1'b1;
        send_bit_l(1'b0, 1'b0);
        chk("t4_valid", 32'(ifl.dout_valid), 32'h1);
        chk("t4_dout",  32'(ifl.dout), 32'h22);
        chk("t4_ovr",   32'(ifl.overrun), 32'h0);
        tick();
        chk("t4_drop",  32'(ifl.dout_valid), 32'h0);

        // 5a: restart after 5 bits; only the new frame is delivered
        for (int i = 0; i < 5; i++) send_bit_l(8'hFF >> i, i == 0);
        chk("t5_cnt5",  32'(ifl.bit_cnt), 32'd5);
        chk("t5_nov",   32'(ifl.dout_valid), 32'h0);
        send_bit_l(1'b0, 1'b1);
        chk("t5_rst1",  32'(ifl.bit_cnt), 32'd1);
        for (int i = 1; i < 8; i++) send_bit_l(8'h5A >> i, 1'b0);
        chk("t5_valid", 32'(ifl.dout_valid), 32'h1);
        chk("t5_dout",  32'(ifl.dout), 32'h5A);
        tick();
        chk("t5_once",  32'(ifl.dout_valid), 32'h0);

        // 5b: asynchronous reset in the middle of a frame
        for (int i = 0; i < 3; i++) send_bit_l(1'b1, i == 0);
        chk("t5_busy",  32'(ifl.busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("t5_ar_d",  32'(ifl.dout), 32'h0);
        chk("t5_ar_b",  32'(ifl.busy), 32'h0);
        chk("t5_ar_c",  32'(ifl.bit_cnt), 32'h0);
        chk("t5_ar_v",  32'(ifl.dout_valid), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        send_frame_l(8'hC3);
        chk("t5_pv",    32'(ifl.dout_valid), 32'h1);
        chk("t5_pd",    32'(ifl.dout), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
